gol_population_counter: RTL

- Downstream consumer of the cell grid. On each generation tick it scans the grid one row at a time and counts the live cells.
- It converts the count to four BCD digits with a sequential double-dabble and drives HEX0..HEX3 (active-low, DE10-Lite format).
- It sits beside the VGA draw path. The top level muxes one grid row onto row_data from row_addr.

---
 rtl/gol_pkg.sv | 27 ++
 rtl/bcd_to_sevenseg.sv | 14 +
 rtl/gol_population_counter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared constants, state type and segment table for the population counter
package gol_pkg;

    localparam int GOL_WIDTH  = 80;
    localparam int GOL_HEIGHT = 60;

    // Smallest counter width able to hold w*h live cells
    function automatic int count_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_BCD,
        ST_DONE
    } pop_state_t;

    // Active-low {dp,g..a}; codes 10-15 never occur and are left blank
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

endpackage

// File: rtl/bcd_to_sevenseg.sv
// rtl/bcd_to_sevenseg.sv - one BCD digit to active-low seven-segment pattern
module bcd_to_sevenseg
    import gol_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    // Table lookup; decimal point stays off through the table contents
    always_comb begin
        seg = SEG_TABLE[digit];
    end

endmodule

// File: rtl/gol_population_counter.sv
// rtl/gol_population_counter.sv - scans the cell grid per tick, counts live cells, shows count on HEX0..HEX3
module gol_population_counter
    import gol_pkg::*;
#(
    parameter int WIDTH  = GOL_WIDTH,
    parameter int HEIGHT = GOL_HEIGHT,
    parameter int CNT_W  = count_width(GOL_WIDTH, GOL_HEIGHT)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        start,
    output logic [$clog2(HEIGHT)-1:0]   row_addr,
    input  logic [WIDTH-1:0]            row_data,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            population,
    output logic [15:0]                 bcd,
    output logic [7:0]                  HEX0,
    output logic [7:0]                  HEX1,
    output logic [7:0]                  HEX2,
    output logic [7:0]                  HEX3
);

    localparam int RA_W = $clog2(HEIGHT);
    localparam int PC_W = $clog2(WIDTH + 1);
    localparam int BC_W = $clog2(CNT_W + 1);
    localparam int SR_W = 16 + CNT_W;

    pop_state_t         state;
    logic               pending;
    logic [CNT_W-1:0]   acc;
    logic [SR_W-1:0]    dd_sr;
    logic [SR_W-1:0]    dd_adj;
    logic [BC_W-1:0]    bit_cnt;
    logic [PC_W-1:0]    row_pop;
    logic [7:0]         seg0, seg1, seg2, seg3;

    assign busy = (state != ST_IDLE);

    // Live cells in the row returned this cycle
    always_comb begin
        row_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row_pop = row_pop + PC_W'(row_data[i]);
        end
    end

    // Double-dabble correction: digits >= 5 get +3 before the shift
    always_comb begin
        dd_adj = dd_sr;
        for (int d = 0; d < 4; d++) begin
            if (dd_adj[CNT_W + 4*d +: 4] >= 4'd5) begin
                dd_adj[CNT_W + 4*d +: 4] = dd_adj[CNT_W + 4*d +: 4] + 4'd3;
            end
        end
    end

    bcd_to_sevenseg u_seg0 (.digit(dd_sr[CNT_W      +: 4]), .seg(seg0));
    bcd_to_sevenseg u_seg1 (.digit(dd_sr[CNT_W + 4  +: 4]), .seg(seg1));
    bcd_to_sevenseg u_seg2 (.digit(dd_sr[CNT_W + 8  +: 4]), .seg(seg2));
    bcd_to_sevenseg u_seg3 (.digit(dd_sr[CNT_W + 12 +: 4]), .seg(seg3));

    // Scan / convert sequencer; visible outputs only move in the DONE cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            row_addr   <= '0;
            done       <= 1'b0;
            pending    <= 1'b0;
            acc        <= '0;
            dd_sr      <= '0;
            bit_cnt    <= '0;
            population <= '0;
            bcd        <= 16'h0000;
            HEX0       <= 8'hC0;
            HEX1       <= 8'hC0;
            HEX2       <= 8'hC0;
            HEX3       <= 8'hC0;
        end else begin
            done <= 1'b0;
            // Requests arriving mid-operation collapse into a single rerun
            if (start && state != ST_IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start || pending) begin
                        state    <= ST_SCAN;
                        acc      <= '0;
                        pending  <= 1'b0;
                        row_addr <= '0;
                    end
                end
                ST_SCAN: begin
                    // row_data lags row_addr by one cycle, so the first cycle has nothing to add
                    if (row_addr != '0) begin
                        acc <= acc + CNT_W'(row_pop);
                    end
                    if (row_addr == RA_W'(HEIGHT - 1)) begin
                        state <= ST_DRAIN;
                    end else begin
                        row_addr <= row_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    acc     <= acc + CNT_W'(row_pop);
                    dd_sr   <= {16'h0000, acc + CNT_W'(row_pop)};
                    bit_cnt <= '0;
                    state   <= ST_BCD;
                end
                ST_BCD: begin
                    dd_sr   <= dd_adj << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BC_W'(CNT_W - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    population <= acc;
                    bcd        <= dd_sr[SR_W-1 -: 16];
                    HEX0       <= seg0;
                    HEX1       <= seg1;
                    HEX2       <= seg2;
                    HEX3       <= seg3;
                    done       <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
